// File: rtl/rnn_x_feeder_if.sv
// Upstream byte stream into the RNN input feeder.
// A byte transfers on a rising edge where s_valid && s_ready; the source holds s_data stable while s_valid is high and s_ready is low.
interface rnn_x_feeder_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/rnn_x_feeder.sv
// Packs upstream bytes little-endian into 32-bit words, queues them in a small FIFO
// and hands one word per i_en request to the RNN core on idata.
module rnn_x_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    rnn_x_feeder_if.slave       s_bus,
    input  logic                busy,
    input  logic                i_en,
    output logic                ready,
    output logic [31:0]         idata,
    output logic [2:0]          level,
    output logic                udf_err
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_q;

    logic accept;
    logic push;
    logic pop;
    logic fifo_full;

    assign fifo_full     = (level == 3'(DEPTH));
    // Only the word-completing byte needs a free slot, so bytes 1-3 keep flowing while full.
    assign s_bus.s_ready = !(fifo_full && (byte_cnt == 2'd3));
    assign accept        = s_bus.s_valid && s_bus.s_ready;
    assign push          = accept && (byte_cnt == 2'd3);
    assign pop           = i_en && (level != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= 3'd0;
            idata    <= 32'd0;
            udf_err  <= 1'b0;
            ready    <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_q[7:0]   <= s_bus.s_data;
                    2'd1:    asm_q[15:8]  <= s_bus.s_data;
                    2'd2:    asm_q[23:16] <= s_bus.s_data;
                    default: asm_q        <= 24'd0;
                endcase
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // An empty FIFO never bypasses a word being pushed on the same edge.
            if (i_en) begin
                if (pop) begin
                    idata  <= fifo_mem[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    idata   <= 32'd0;
                    udf_err <= 1'b1;
                end
            end

            level <= level + {2'b00, push} - {2'b00, pop};
            ready <= (level != 3'd0) && !busy;
        end
    end

    // Storage needs no reset: pointers and level decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_bus.s_data, asm_q};
        end
    end
endmodule

// File: tb/tb_rnn_x_feeder.sv
// Directed bench for rnn_x_feeder: packing, FIFO full/empty edges, underflow,
// simultaneous push/pop, busy-gated ready and mid-operation reset.
module tb_rnn_x_feeder;
    logic        clk;
    logic        reset;
    logic        busy;
    logic        i_en;
    logic        ready;
    logic [31:0] idata;
    logic [2:0]  level;
    logic        udf_err;

    int n_checks;
    int n_fail;

    rnn_x_feeder_if bus ();

    rnn_x_feeder #(.DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_bus   (bus.slave),
        .busy    (busy),
        .i_en    (i_en),
        .ready   (ready),
        .idata   (idata),
        .level   (level),
        .udf_err (udf_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    // driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic pop_word();
        i_en = 1'b1;
        tick();
        i_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        busy        = 1'b0;
        i_en        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // reset state
        tick();
        chk("rst_idata", idata, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_udf", {31'd0, udf_err}, 32'd0);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // single word pack and pop
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("pack_level", {29'd0, level}, 32'd1);
        chk("pack_ready_lag", {31'd0, ready}, 32'd0);
        tick();
        chk("pack_ready", {31'd0, ready}, 32'd1);
        pop_word();
        chk("pack_idata", idata, 32'h44332211);
        chk("pack_level0", {29'd0, level}, 32'd0);
        tick();
        chk("pack_idata_hold", idata, 32'h44332211);
        chk("pack_ready_drop", {31'd0, ready}, 32'd0);

        // underflow
        pop_word();
        chk("udf_idata", idata, 32'h0);
        chk("udf_flag", {31'd0, udf_err}, 32'd1);
        chk("udf_level", {29'd0, level}, 32'd0);

        // fill to full, then three more bytes while full
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_s_ready", {31'd0, bus.s_ready}, 32'd1);
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'h13);
        chk("full_partial_level", {29'd0, level}, 32'd4);
        chk("full_s_ready_low", {31'd0, bus.s_ready}, 32'd0);

        // 20th byte held back until a pop frees a slot
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h14;
        tick();
        tick();
        chk("held_level", {29'd0, level}, 32'd4);
        chk("held_s_ready", {31'd0, bus.s_ready}, 32'd0);
        i_en = 1'b1;
        tick();
        i_en = 1'b0;
        chk("held_pop_idata", idata, 32'h04030201);
        chk("held_pop_level", {29'd0, level}, 32'd3);
        chk("held_s_ready_up", {31'd0, bus.s_ready}, 32'd1);
        tick();
        bus.s_valid = 1'b0;
        chk("held_accept_level", {29'd0, level}, 32'd4);
        chk("held_accept_s_ready", {31'd0, bus.s_ready}, 32'd1);

        // drain, underflow flag stays sticky
        pop_word();
        chk("drain0", idata, 32'h08070605);
        chk("udf_sticky", {31'd0, udf_err}, 32'd1);
        pop_word();
        chk("drain1", idata, 32'h0C0B0A09);
        pop_word();
        chk("drain2", idata, 32'h100F0E0D);
        pop_word();
        chk("drain3", idata, 32'h14131211);
        chk("drain_level", {29'd0, level}, 32'd0);

        // simultaneous push and pop at level 1
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        send_byte(8'h24);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        i_en = 1'b1;
        send_byte(8'h34);
        i_en = 1'b0;
        chk("pushpop_level", {29'd0, level}, 32'd1);
        chk("pushpop_idata", idata, 32'h24232221);
        pop_word();
        chk("pushpop_tail", idata, 32'h34333231);
        chk("pushpop_level0", {29'd0, level}, 32'd0);

        // simultaneous push and pop at level 0: no bypass
        send_byte(8'h51);
        send_byte(8'h52);
        send_byte(8'h53);
        i_en = 1'b1;
        send_byte(8'h54);
        i_en = 1'b0;
        chk("nobypass_idata", idata, 32'h0);
        chk("nobypass_level", {29'd0, level}, 32'd1);
        pop_word();
        chk("nobypass_pop", idata, 32'h54535251);

        // busy gating of ready
        busy = 1'b1;
        for (int i = 0; i < 12; i++) send_byte(8'(8'h61 + i));
        tick();
        chk("busy_level", {29'd0, level}, 32'd3);
        chk("busy_ready", {31'd0, ready}, 32'd0);
        busy = 1'b0;
        tick();
        chk("busy_release_ready", {31'd0, ready}, 32'd1);
        busy = 1'b1;
        tick();
        chk("busy_again_ready", {31'd0, ready}, 32'd0);
        busy = 1'b0;
        tick();

        // reset mid-operation: two words queued and a half-built word
        pop_word();
        chk("pre_rst_idata", idata, 32'h64636261);
        chk("pre_rst_level", {29'd0, level}, 32'd2);
        send_byte(8'h71);
        send_byte(8'h72);
        chk("pre_rst_ready", {31'd0, ready}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_idata", idata, 32'h0);
        chk("async_rst_ready", {31'd0, ready}, 32'd0);
        chk("async_rst_level", {29'd0, level}, 32'd0);
        chk("async_rst_udf", {31'd0, udf_err}, 32'd0);
        chk("async_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        tick();
        reset = 1'b0;
        send_byte(8'hA0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        chk("post_rst_level", {29'd0, level}, 32'd1);
        pop_word();
        chk("post_rst_word", idata, 32'hA3A2A1A0);
        chk("post_rst_udf", {31'd0, udf_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rnn_x_feeder.md
RNN_X_FEEDER -- requirements
Module: rnn_x_feeder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port s_valid, input, 1, upstream byte valid.
REQ-004 SHALL have port s_data, input, 8, upstream byte.
REQ-005 SHALL have port s_ready, output, 1, byte accepted when s_valid & s_ready at rising edge.
REQ-006 SHALL have port busy, input, 1, RNN core busy flag.
REQ-007 SHALL have port i_en, input, 1, RNN request for next 32-bit input word.
REQ-008 SHALL have port ready, output, 1, start request to RNN core.
REQ-009 SHALL have port idata, output, 32, current input word presented to RNN core.
REQ-010 SHALL have port level, output, 3, FIFO word count 0..4.
REQ-011 SHALL have port udf_err, output, 1, sticky underflow flag.
REQ-012 SHALL have parameter DEPTH, default 4, FIFO depth in 32-bit words (fixed at 4 for this release).

Function
REQ-013 SHALL pack accepted bytes little-endian: 1st byte -> bits 7:0, 2nd -> 15:8, 3rd -> 23:16, 4th -> 31:24.
REQ-014 SHALL keep a 2-bit byte counter, wrapping 3->0; the 4th byte's acceptance pushes the assembled word into the FIFO in that same edge.
REQ-015 SHALL drive s_ready = !(level==4 && byte_cnt==3) combinationally; bytes 1-3 accepted while FIFO full.
REQ-016 SHALL on a rising edge with i_en=1 and level>0: idata <= FIFO head, pop head (1-cycle latency; idata valid the cycle after the request and held until next request).
REQ-017 SHALL on a rising edge with i_en=1 and level==0: idata <= 0, set udf_err, no level change.
REQ-018 SHALL on simultaneous push and pop keep level unchanged; pop returns the old head, pushed word goes to tail; when level==0 the new word is not bypassed to idata.
REQ-019 SHALL hold idata unchanged when i_en=0.
REQ-020 SHALL register ready <= (level!=0) && !busy; ready SHALL deassert the cycle after busy is sampled high.
REQ-021 SHALL implement FIFO as circular buffer with 2-bit read/write pointers wrapping 3->0.
REQ-022 SHALL ignore s_data when s_valid=0 or s_ready=0 (no counter or data change).
REQ-023 SHALL keep udf_err set until reset.
REQ-024 SHALL preserve a partially assembled word across FIFO full periods.

Reset
REQ-025 SHALL on reset asynchronously clear: idata=0, ready=0, level=0, udf_err=0, byte_cnt=0, pointers=0, assembly register=0.
REQ-026 SHALL discard any partial word and FIFO content on reset mid-operation; s_ready=1 while reset is asserted.
REQ-027 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-028 SHALL pass: bytes 0x11,0x22,0x33,0x44 with busy=0 -> level=1 after 4th edge, ready=1 next cycle; i_en pulse -> idata=0x44332211 next cycle, level=0.
REQ-029 SHALL pass: stream 16 bytes, no i_en -> level=4; 17th-19th bytes accepted, 20th held with s_ready=0 until an i_en pop, then accepted the same cycle s_ready rises.
REQ-030 SHALL pass: i_en with level=0 -> idata=0x00000000, udf_err=1 and remains 1 after later valid pops.
REQ-031 SHALL pass: level=1, 4th byte of new word and i_en same edge -> level stays 1, idata = old head.
REQ-032 SHALL pass: reset asserted after 2 bytes of a word and 2 words queued -> all outputs zero immediately; next 4 bytes 0xA0..0xA3 form 0xA3A2A1A0.
REQ-033 SHALL pass: busy=1 with level=3 -> ready=0; busy falls -> ready=1 one cycle later.
